// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage between execute and writeback.
// Drives an SRAM-like data bus (req / addr_ok / data_ok), checks alignment,
// and returns extended load data plus address-error flags to writeback.
// Optional feature macro: MEM_UNALIGNED_LWLR_EN enables LWL/LWR/SWL/SWR (ops 9-12).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// once valid is raised it and its payload stay stable until that edge.
module mem_access_stage #(
    parameter int KSEG_STRIP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_rt_old,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_ex_adel,
    output logic        out_ex_ades,
    output logic [31:0] out_badvaddr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
`ifdef MEM_UNALIGNED_LWLR_EN
    localparam logic [3:0] OP_LWL = 4'd9;
    localparam logic [3:0] OP_LWR = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;
`endif

    state_t      r_state, w_state_nxt;
    logic        r_in_ready, w_in_ready_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_out_rdata, w_out_rdata_nxt;
    logic        r_adel, w_adel_nxt;
    logic        r_ades, w_ades_nxt;
    logic [31:0] r_badv, w_badv_nxt;
    logic        r_req, w_req_nxt;
    logic        r_wr, w_wr_nxt;
    logic [1:0]  r_size, w_size_nxt;
    logic [31:0] r_daddr, w_daddr_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_op, w_op_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic [31:0] r_rt_old, w_rt_old_nxt;

    logic        w_acc_load, w_acc_store, w_acc_unal, w_misaligned;
    logic [1:0]  w_acc_size;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_wdata, w_addr_al, w_bus_addr, w_load_result;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [1:0]  w_in_lane;

    assign w_in_lane = in_addr[1:0];

    // Classify the incoming op: direction, access size, and whether it is an unaligned-merge op.
    always_comb begin
        w_acc_load  = 1'b0;
        w_acc_store = 1'b0;
        w_acc_unal  = 1'b0;
        w_acc_size  = 2'd0;
        case (in_op)
            OP_LB, OP_LBU: begin w_acc_load = 1'b1; w_acc_size = 2'd0; end
            OP_LH, OP_LHU: begin w_acc_load = 1'b1; w_acc_size = 2'd1; end
            OP_LW:         begin w_acc_load = 1'b1; w_acc_size = 2'd2; end
            OP_SB:         begin w_acc_store = 1'b1; w_acc_size = 2'd0; end
            OP_SH:         begin w_acc_store = 1'b1; w_acc_size = 2'd1; end
            OP_SW:         begin w_acc_store = 1'b1; w_acc_size = 2'd2; end
`ifdef MEM_UNALIGNED_LWLR_EN
            OP_LWL, OP_LWR: begin w_acc_load = 1'b1; w_acc_unal = 1'b1; w_acc_size = 2'd2; end
            OP_SWL, OP_SWR: begin w_acc_store = 1'b1; w_acc_unal = 1'b1; w_acc_size = 2'd2; end
`endif
            default: ;
        endcase
    end

    assign w_misaligned = !w_acc_unal &&
                          (((w_acc_size == 2'd1) && in_addr[0]) ||
                           ((w_acc_size == 2'd2) && (in_addr[1:0] != 2'b00)));
    // Merge ops always address the containing word.
    assign w_addr_al  = w_acc_unal ? {in_addr[31:2], 2'b00} : in_addr;
    assign w_bus_addr = (KSEG_STRIP != 0) ? {3'b000, w_addr_al[28:0]} : w_addr_al;

    // Byte-lane strobe and lane-replicated/shifted store data for the incoming op.
    always_comb begin
        w_st_strb  = 4'b0000;
        w_st_wdata = 32'h0;
        case (in_op)
            OP_SB: begin w_st_strb = 4'b0001 << w_in_lane; w_st_wdata = {4{in_wdata[7:0]}}; end
            OP_SH: begin w_st_strb = w_in_lane[1] ? 4'b1100 : 4'b0011; w_st_wdata = {2{in_wdata[15:0]}}; end
            OP_SW: begin w_st_strb = 4'b1111; w_st_wdata = in_wdata; end
`ifdef MEM_UNALIGNED_LWLR_EN
            // ~lane equals 3-lane for a two-bit lane.
            OP_SWL: begin w_st_strb = 4'b1111 >> (~w_in_lane); w_st_wdata = in_wdata >> {~w_in_lane, 3'b000}; end
            OP_SWR: begin w_st_strb = 4'b1111 << w_in_lane; w_st_wdata = in_wdata << {w_in_lane, 3'b000}; end
`endif
            default: ;
        endcase
    end

    assign w_byte = data_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? data_rdata[31:16] : data_rdata[15:0];

    // Extend or merge the returned bus word according to the latched op; stores yield 0.
    always_comb begin
        w_load_result = 32'h0;
        case (r_op)
            OP_LB:  w_load_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_load_result = {24'h0, w_byte};
            OP_LH:  w_load_result = {{16{w_half[15]}}, w_half};
            OP_LHU: w_load_result = {16'h0, w_half};
            OP_LW:  w_load_result = data_rdata;
`ifdef MEM_UNALIGNED_LWLR_EN
            OP_LWL: w_load_result = (data_rdata << {~r_lane, 3'b000}) |
                                    (r_rt_old & ~(32'hFFFF_FFFF << {~r_lane, 3'b000}));
            OP_LWR: w_load_result = (data_rdata >> {r_lane, 3'b000}) |
                                    (r_rt_old & ~(32'hFFFF_FFFF >> {r_lane, 3'b000}));
`endif
            default: ;
        endcase
    end

`ifndef MEM_UNALIGNED_LWLR_EN
    // Old rt value only feeds the merge ops.
    logic w_unused_rt;
    assign w_unused_rt = ^r_rt_old;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        w_out_rdata_nxt = r_out_rdata;
        w_adel_nxt      = r_adel;
        w_ades_nxt      = r_ades;
        w_badv_nxt      = r_badv;
        w_req_nxt       = r_req;
        w_wr_nxt        = r_wr;
        w_size_nxt      = r_size;
        w_daddr_nxt     = r_daddr;
        w_wstrb_nxt     = r_wstrb;
        w_wdata_nxt     = r_wdata;
        w_op_nxt        = r_op;
        w_lane_nxt      = r_lane;
        w_rt_old_nxt    = r_rt_old;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_in_ready_nxt  = 1'b0;
                    w_op_nxt        = in_op;
                    w_lane_nxt      = w_in_lane;
                    w_rt_old_nxt    = in_rt_old;
                    w_out_rdata_nxt = 32'h0;
                    w_adel_nxt      = 1'b0;
                    w_ades_nxt      = 1'b0;
                    w_badv_nxt      = 32'h0;
                    if (!w_acc_load && !w_acc_store) begin
                        w_state_nxt     = S_DONE;
                        w_out_valid_nxt = 1'b1;
                    end else if (w_misaligned) begin
                        w_state_nxt     = S_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_adel_nxt      = w_acc_load;
                        w_ades_nxt      = w_acc_store;
                        w_badv_nxt      = in_addr;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_req_nxt   = 1'b1;
                        w_wr_nxt    = w_acc_store;
                        w_size_nxt  = w_acc_size;
                        w_daddr_nxt = w_bus_addr;
                        w_wstrb_nxt = w_acc_store ? w_st_strb : 4'b0000;
                        w_wdata_nxt = w_acc_store ? w_st_wdata : 32'h0;
                    end
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    w_req_nxt   = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_size_nxt  = 2'd0;
                    w_daddr_nxt = 32'h0;
                    w_wstrb_nxt = 4'b0000;
                    w_wdata_nxt = 32'h0;
                    if (data_data_ok) begin
                        w_state_nxt     = S_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_out_rdata_nxt = w_load_result;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    w_state_nxt     = S_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_out_rdata_nxt = w_load_result;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_out_rdata_nxt = 32'h0;
                    w_adel_nxt      = 1'b0;
                    w_ades_nxt      = 1'b0;
                    w_badv_nxt      = 32'h0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_rdata <= 32'h0;
            r_adel      <= 1'b0;
            r_ades      <= 1'b0;
            r_badv      <= 32'h0;
            r_req       <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_daddr     <= 32'h0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_op        <= 4'd0;
            r_lane      <= 2'd0;
            r_rt_old    <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_rdata <= w_out_rdata_nxt;
            r_adel      <= w_adel_nxt;
            r_ades      <= w_ades_nxt;
            r_badv      <= w_badv_nxt;
            r_req       <= w_req_nxt;
            r_wr        <= w_wr_nxt;
            r_size      <= w_size_nxt;
            r_daddr     <= w_daddr_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wdata     <= w_wdata_nxt;
            r_op        <= w_op_nxt;
            r_lane      <= w_lane_nxt;
            r_rt_old    <= w_rt_old_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_rdata    = r_out_rdata;
    assign out_ex_adel  = r_adel;
    assign out_ex_ades  = r_ades;
    assign out_badvaddr = r_badv;
    assign data_req     = r_req;
    assign data_wr      = r_wr;
    assign data_size    = r_size;
    assign data_addr    = r_daddr;
    assign data_wstrb   = r_wstrb;
    assign data_wdata   = r_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized transactions for mem_access_stage,
// checked against a byte-level reference model of the memory-stage rules.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_wdata, in_rt_old, out_rdata, out_badvaddr;
    logic        out_ex_adel, out_ex_ades;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size, dbg_state;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int req_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata, last_badv, last_bwdata, last_baddr;
    logic [3:0]  last_strb;
    logic        last_adel, last_ades;

    typedef struct {
        bit          bus;
        bit          chk_size;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [31:0] badv;
    } exp_t;

    // clock / reset
    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rt_old(in_rt_old),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_ex_adel(out_ex_adel), .out_ex_ades(out_ex_ades), .out_badvaddr(out_badvaddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .o_dbg_state(dbg_state)
    );

    // bus activity counters
    always @(posedge clk) begin
        if (resetn && data_req && data_addr_ok) hs_cnt <= hs_cnt + 1;
        if (resetn && data_req) req_cnt <= req_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[8*i +: 8];
    endfunction

    // reference model: what the stage must do for one op
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd);
        exp_t e;
        int a, nb;
        bit ld, st, unal;
        logic [31:0] b, h, base;
        e.bus = 0; e.chk_size = 1; e.wr = 0; e.size = 0; e.addr = 0; e.strb = 0;
        e.wdata = 0; e.rdata = 0; e.adel = 0; e.ades = 0; e.badv = 0;
        a = int'(addr % 4);
        ld = 0; st = 0; unal = 0; nb = 0;
        case (op)
            4'd1, 4'd2: begin ld = 1; nb = 1; end
            4'd3, 4'd4: begin ld = 1; nb = 2; end
            4'd5:       begin ld = 1; nb = 4; end
            4'd6:       begin st = 1; nb = 1; end
            4'd7:       begin st = 1; nb = 2; end
            4'd8:       begin st = 1; nb = 4; end
`ifdef MEM_UNALIGNED_LWLR_EN
            4'd9, 4'd10:  begin ld = 1; unal = 1; nb = 4; end
            4'd11, 4'd12: begin st = 1; unal = 1; nb = 4; end
`endif
            default: ;
        endcase
        if (!ld && !st) return e;
        if (!unal && (a % nb) != 0) begin
            e.adel = ld; e.ades = st; e.badv = addr;
            return e;
        end
        e.bus = 1;
        e.wr = st;
        e.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        base = unal ? addr - 32'(a) : addr;
        e.addr = base % 32'h2000_0000;
        b = (rd >> (8*a)) % 256;
        h = (rd >> (8*a)) % 65536;
        case (op)
            4'd1: e.rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4'd2: e.rdata = b;
            4'd3: e.rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4'd4: e.rdata = h;
            4'd5: e.rdata = rd;
            4'd6: begin e.strb = 4'(1 << a); e.wdata = (wd % 256) * 32'h0101_0101; end
            4'd7: begin e.strb = (a >= 2) ? 4'b1100 : 4'b0011; e.wdata = (wd % 65536) * 32'h0001_0001; end
            4'd8: begin e.strb = 4'hF; e.wdata = wd; end
`ifdef MEM_UNALIGNED_LWLR_EN
            4'd9:  for (int i = 0; i < 4; i++)
                       e.rdata[8*i +: 8] = (i >= 3 - a) ? byte_of(rd, i - (3 - a)) : byte_of(rt, i);
            4'd10: for (int i = 0; i < 4; i++)
                       e.rdata[8*i +: 8] = (i <= 3 - a) ? byte_of(rd, i + a) : byte_of(rt, i);
            4'd11: begin
                e.chk_size = 0;
                for (int i = 0; i <= a; i++) begin e.strb[i] = 1'b1; e.wdata[8*i +: 8] = byte_of(wd, i + 3 - a); end
            end
            4'd12: begin
                e.chk_size = 0;
                for (int i = a; i < 4; i++) begin e.strb[i] = 1'b1; e.wdata[8*i +: 8] = byte_of(wd, i - a); end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    // driver: issue one op, act as the bus slave, then drain the result
    task automatic do_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd,
                          input int alat, input int dlat, input int hold);
        exp_t e;
        int hs0, req0;
        logic [31:0] exp_rd;
        e = model(op, addr, wd, rt, rd);
        exp_q.push_back(e.rdata);
        @(negedge clk);
        check({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        hs0 = hs_cnt; req0 = req_cnt;
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_rt_old = rt;
        @(negedge clk);
        in_valid = 1'b0; in_op = 4'($urandom()); in_addr = $urandom(); in_wdata = $urandom(); in_rt_old = $urandom();
        check({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        if (e.bus) begin
            last_strb = data_wstrb; last_bwdata = data_wdata; last_baddr = data_addr;
            for (int k = 0; k <= alat; k++) begin
                check({name, ".req"}, 32'(data_req), 32'd1);
                check({name, ".wr"}, 32'(data_wr), 32'(e.wr));
                if (e.chk_size) check({name, ".size"}, 32'(data_size), 32'(e.size));
                check({name, ".addr"}, data_addr, e.addr);
                check({name, ".wstrb"}, 32'(data_wstrb), 32'(e.strb));
                if (e.wr) check({name, ".wdata"}, data_wdata, e.wdata);
                check({name, ".valid_early"}, 32'(out_valid), 32'd0);
                if (k == alat) begin
                    data_addr_ok = 1'b1;
                    if (dlat == 0) begin data_data_ok = 1'b1; data_rdata = rd; end
                end else if ($urandom_range(0, 3) == 0) begin
                    data_data_ok = 1'b1; data_rdata = $urandom();
                end
                @(negedge clk);
                data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom();
            end
            check({name, ".req_drop"}, 32'(data_req), 32'd0);
            for (int k = 1; k <= dlat; k++) begin
                check({name, ".valid_wait"}, 32'(out_valid), 32'd0);
                if (k == dlat) begin data_data_ok = 1'b1; data_rdata = rd; end
                @(negedge clk);
                data_data_ok = 1'b0; data_rdata = $urandom();
            end
        end else begin
            check({name, ".no_req"}, 32'(data_req), 32'd0);
        end
        exp_rd = exp_q.pop_front();
        last_rdata = out_rdata; last_adel = out_ex_adel; last_ades = out_ex_ades; last_badv = out_badvaddr;
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".rdata"}, out_rdata, exp_rd);
        check({name, ".adel"}, 32'(out_ex_adel), 32'(e.adel));
        check({name, ".ades"}, 32'(out_ex_ades), 32'(e.ades));
        check({name, ".badv"}, out_badvaddr, e.badv);
        check({name, ".handshakes"}, 32'(hs_cnt - hs0), e.bus ? 32'd1 : 32'd0);
        check({name, ".req_cycles"}, 32'(req_cnt - req0), e.bus ? 32'(alat + 1) : 32'd0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            data_data_ok = ($urandom_range(0, 1) == 1); data_rdata = $urandom();
            @(negedge clk);
            data_data_ok = 1'b0;
            check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({name, ".hold_rdata"}, out_rdata, exp_rd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({name, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r_addr;
        resetn = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'h0; in_wdata = 32'h0;
        in_rt_old = 32'h0; out_ready = 1'b0; data_addr_ok = 1'b0; data_rdata = 32'h0; data_data_ok = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_rdata", out_rdata, 32'd0);
        check("rst.adel", 32'(out_ex_adel), 32'd0);
        check("rst.ades", 32'(out_ex_ades), 32'd0);
        check("rst.badv", out_badvaddr, 32'd0);
        check("rst.req", 32'(data_req), 32'd0);
        check("rst.wr", 32'(data_wr), 32'd0);
        check("rst.size", 32'(data_size), 32'd0);
        check("rst.addr", data_addr, 32'd0);
        check("rst.wstrb", 32'(data_wstrb), 32'd0);
        check("rst.wdata", data_wdata, 32'd0);
        resetn = 1'b1;

        do_txn("lb", 4'd1, 32'h8000_0003, $urandom(), $urandom(), 32'h8F00_0000, 0, 0, 0);
        check("lb.const_rdata", last_rdata, 32'hFFFF_FF8F);
        check("lb.const_addr", last_baddr, 32'h0000_0003);
        check("lb.const_strb", 32'(last_strb), 32'd0);
        do_txn("lbu", 4'd2, 32'h8000_0003, $urandom(), $urandom(), 32'h8F00_0000, 0, 0, 1);
        check("lbu.const_rdata", last_rdata, 32'h0000_008F);
        do_txn("sh", 4'd7, 32'hA000_1002, 32'h1234_ABCD, $urandom(), $urandom(), 1, 1, 0);
        check("sh.const_strb", 32'(last_strb), 32'hC);
        check("sh.const_wdata", last_bwdata, 32'hABCD_ABCD);
        do_txn("lw_mis", 4'd5, 32'h8000_0006, $urandom(), $urandom(), $urandom(), 0, 0, 0);
        check("lw_mis.const_adel", 32'(last_adel), 32'd1);
        check("lw_mis.const_badv", last_badv, 32'h8000_0006);
        do_txn("sw_mis", 4'd8, 32'h8000_0006, $urandom(), $urandom(), $urandom(), 0, 0, 0);
        check("sw_mis.const_ades", 32'(last_ades), 32'd1);
        do_txn("lw_slow", 4'd5, 32'h8000_0020, $urandom(), $urandom(), 32'h1357_9BDF, 3, 2, 4);
        check("lw_slow.const_rdata", last_rdata, 32'h1357_9BDF);

        // reset while waiting for data, then a stray data_ok afterwards
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h8000_0010;
        @(negedge clk);
        in_valid = 1'b0; data_addr_ok = 1'b1;
        check("rstmid.req", 32'(data_req), 32'd1);
        @(negedge clk);
        data_addr_ok = 1'b0;
        check("rstmid.wait_valid", 32'(out_valid), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        check("rstmid.in_ready", 32'(in_ready), 32'd1);
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rstmid.stray_valid", 32'(out_valid), 32'd0);
            check("rstmid.stray_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        do_txn("lw_after_rst", 4'd5, 32'h8000_0040, $urandom(), $urandom(), 32'hCAFE_F00D, 0, 1, 0);
        check("lw_after_rst.const", last_rdata, 32'hCAFE_F00D);

        do_txn("lwl", 4'd9, 32'h8000_0001, $urandom(), 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 0);
`ifdef MEM_UNALIGNED_LWLR_EN
        check("lwl.const_rdata", last_rdata, 32'hCCDD_3344);
`else
        check("lwl.const_rdata", last_rdata, 32'h0000_0000);
`endif

        for (int n = 0; n < 80; n++) begin
            r_addr = $urandom();
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            do_txn("rand", 4'($urandom_range(0, 15)), r_addr, $urandom(), $urandom(), $urandom(),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage. It consumes the effective address, store data and memory op that execute produces.
- Drives the SRAM-like data bus (req / addr_ok / data_ok) and checks alignment.
- Extends load data by byte lane and returns the load result with any exception flags to writeback.
- Handles one transaction at a time with a valid/ready handshake on both sides.

Parameters:
- KSEG_STRIP, 1, when 1 data_addr = {3'b000, addr[28:0]} (kseg0/kseg1 direct map); when 0 the address passes through unchanged.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  execute presents a memory op
- in_ready  out  1  stage can accept (state IDLE)
- in_op  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LWL, 10 LWR, 11 SWL, 12 SWR
- in_addr  in  32  effective address from execute ALU
- in_wdata  in  32  store data (rt value)
- in_rt_old  in  32  current rt value, used for the LWL/LWR merge
- out_valid  out  1  result ready for writeback
- out_ready  in  1  writeback accepts
- out_rdata  out  32  extended/merged load data; 0 for stores and NOP
- out_ex_adel  out  1  load address error
- out_ex_ades  out  1  store address error
- out_badvaddr  out  32  faulting in_addr when either error flag is set, else 0
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte write strobe; 0 for loads
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  data phase complete

Behaviour:
- All state and outputs are registered. Reset is synchronous on resetn=0.
  - state=IDLE; in_ready=1.
  - Every other output is 0.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: when in_valid && in_ready, latch the op, address and data.
  - NOP goes to DONE with out_rdata=0.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) goes to DONE with adel (loads) or ades (stores) set and badvaddr=in_addr. No bus request is issued.
  - Otherwise go to REQ.
- REQ: data_req=1. data_wr, data_size, data_addr, data_wstrb and data_wdata stay stable until data_addr_ok=1.
  - On addr_ok: go to WAIT, or go straight to DONE if data_ok=1 in the same cycle.
  - data_req drops in the cycle after addr_ok.
- WAIT: hold until data_ok. On data_ok, capture the result (loads) and go to DONE.
- DONE: out_valid=1 and outputs held until out_ready=1. Then return to IDLE; in_ready=1 the next cycle.
- Minimum latency with zero-wait bus: accept at edge T, req visible T+1, addr_ok and data_ok at T+1, out_valid at T+2.
- Lane a=addr[1:0]:
  - SB: strobe 1<<a, wdata={4{b}}.
  - SH: strobe a[1]?1100:0011, wdata={2{h}}.
  - SW: strobe 1111.
- LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW passes the word.
- data_data_ok seen in IDLE, REQ or DONE is ignored, including a response to a transaction abandoned by reset.
- Reset mid-transaction returns to IDLE immediately with no output pulse.

Optional Feature:
- Macro: MEM_UNALIGNED_LWLR_EN.
- Defined: ops 9-12 are supported, always aligned and never fault.
  - Data address is addr & ~3. LWL/LWR use data_size=2.
  - LWL merges data_rdata into the upper (a+1) bytes of in_rt_old.
  - LWR merges data_rdata[31:8a] into the lower (4-a) bytes of in_rt_old.
  - SWL: strobe = bytes 0..a, with wdata shifted right by 8(3-a).
  - SWR: strobe = bytes a..3, with wdata shifted left by 8a.
- Undefined: ops 9-15 are treated as NOP (no bus access, out_rdata=0, no exception).

Test Plan:
- LB at 0x80000003, data_rdata=0x8F000000 -> data_addr=0x00000003, size=0, strobe=0000; out_rdata=0xFFFFFF8F. The LBU equivalent gives 0x0000008F.
- SH at 0xA0001002, wdata=0x1234ABCD -> wstrb=1100, data_wdata=0xABCDABCD, data_wr=1; out_valid with no exception.
- LW at 0x80000006 -> no data_req ever, out_ex_adel=1, out_badvaddr=0x80000006. The SW equivalent sets ades.
- Slave delays addr_ok 3 cycles and data_ok 2 more -> req attributes stable throughout; exactly one addr_ok handshake; out_valid on the cycle after data_ok. Holding out_ready=0 for 4 cycles keeps out_rdata and out_valid stable.
- resetn=0 in WAIT, then data_ok pulses after reset -> returns to IDLE, out_valid stays 0, the next LW completes normally.
- With MEM_UNALIGNED_LWLR_EN: LWL addr 0x80000001, rdata=0xAABBCCDD, rt_old=0x11223344 -> out_rdata=0xCCDD3344. Without the macro, op 9 gives out_rdata=0 and no bus request.
